mac_neuron: RTL and testbench

//   Parametrised fixed-point artificial-neural-network neuron.
//   - Accepts N_IN (coef, data) pairs over a valid/ready stream.
//   - Computes y = act(bias + sum(coef*data)) with a full-precision accumulator.
//   - Saturates the result to DW bits, applies a selectable activation and holds it on a valid/ready output.
//   - Building block for network layers: one instance per node, driven by the layer sequencer.

---
 rtl/mac_neuron_if.sv | 31 +++
 rtl/mac_neuron.sv | 169 ++++++++++++++++
 tb/tb_mac_neuron.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_neuron_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_neuron_if
//  Description : Operand input stream and result output stream of a neuron.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_neuron_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] coef;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] node_out;
    logic          sat;

    // Sequencer side: drives operand pairs, consumes results
    modport master (
        output in_valid, coef, data_in, out_ready,
        input  in_ready, out_valid, node_out, sat
    );

    // Neuron side
    modport slave (
        input  in_valid, coef, data_in, out_ready,
        output in_ready, out_valid, node_out, sat
    );
endinterface
`default_nettype wire

// File: rtl/mac_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : mac_neuron
//  Description : Fixed-point neuron, y = act(bias + sum(coef*data)).
//                Full-precision accumulation, saturation to DW bits and a
//                selectable activation (identity/ReLU/hard-sigmoid/step).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_neuron #(
    parameter int N_IN  = 64,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 2*DW + $clog2(N_IN) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [1:0]    act_mode,
    input  logic [DW-1:0] bias,
    mac_neuron_if.slave   bus,
    output logic          busy
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [CNT_W-1:0]        c_last    = CNT_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0]    c_one     = {{(DW-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [DW-1:0]    c_half    = c_one >>> 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ACT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_mode;

    logic signed [2*DW-1:0]  w_coef_ext;
    logic signed [2*DW-1:0]  w_data_ext;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [DW-1:0]    w_x;
    logic signed [DW-1:0]    w_hs;
    logic signed [DW-1:0]    w_act;
    logic                    w_clip;

    // Operands widened to 2*DW so the truncated product is exact
    assign w_coef_ext = {{DW{bus.coef[DW-1]}}, bus.coef};
    assign w_data_ext = {{DW{bus.data_in[DW-1]}}, bus.data_in};
    assign w_prod     = w_coef_ext * w_data_ext;
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias};

    // Back to the operand Q format; arithmetic shift truncates toward -inf
    assign w_shift = r_acc >>> FRAC;

    // Clamp the rescaled sum to the DW range and flag clipping
    always_comb begin
        w_clip = 1'b0;
        w_x    = w_shift[DW-1:0];
        if (w_shift > c_sat_max) begin
            w_clip = 1'b1;
            w_x    = c_sat_max[DW-1:0];
        end else if (w_shift < c_sat_min) begin
            w_clip = 1'b1;
            w_x    = c_sat_min[DW-1:0];
        end
    end

    // Hard-sigmoid pre-clamp term; x/4 + 0.5 cannot overflow DW since FRAC < DW-1
    assign w_hs = (w_x >>> 2) + c_half;

    // Activation on the clamped value, selected by the mode latched at start
    always_comb begin
        w_act = w_x;
        case (r_mode)
            2'd0: w_act = w_x;
            2'd1: w_act = w_x[DW-1] ? '0 : w_x;
            2'd2: begin
                if (w_hs[DW-1])
                    w_act = '0;
                else if (w_hs > c_one)
                    w_act = c_one;
                else
                    w_act = w_hs;
            end
            default: w_act = (!w_x[DW-1] && (w_x != '0)) ? c_one : '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (r_cnt == c_last))
                    w_state_nxt = S_ACT;
            end
            S_ACT: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator, beat counter, latched mode and registered result
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_mode       <= '0;
            bus.node_out <= '0;
            bus.sat      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= w_bias_ext <<< FRAC;
                        r_cnt  <= '0;
                        r_mode <= act_mode;
                    end
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    bus.node_out <= w_act;
                    bus.sat      <= w_clip;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_neuron
//  Description : Self-checking bench for mac_neuron (N_IN=4, DW=16, FRAC=8)
//                against an integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_neuron;

    localparam int N_IN = 4;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam longint ONE = longint'(1) << FRAC;

    logic          clk      = 1'b0;
    logic          n_rst    = 1'b0;
    logic          start    = 1'b0;
    logic [1:0]    act_mode = 2'd0;
    logic [DW-1:0] bias     = '0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] t_coef [N_IN];
    logic [DW-1:0] t_data [N_IN];
    logic [DW-1:0] got;

    mac_neuron_if #(.DW(DW)) bus ();

    mac_neuron #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .act_mode (act_mode),
        .bias     (bias),
        .bus      (bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Count a comparison and report any mismatch
    task automatic check_value(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact sum, floor-rescale, saturate, activate
    function automatic void model(input logic [1:0] m, input logic [DW-1:0] b,
                                  output logic [DW-1:0] y, output logic s);
        longint acc, x, r;
        acc = longint'($signed(b)) * ONE;
        for (int k = 0; k < N_IN; k++)
            acc += longint'($signed(t_coef[k])) * longint'($signed(t_data[k]));
        x = acc >>> FRAC;
        s = 1'b0;
        if (x > 32767)  begin x = 32767;  s = 1'b1; end
        if (x < -32768) begin x = -32768; s = 1'b1; end
        case (m)
            2'd0: r = x;
            2'd1: r = (x < 0) ? 0 : x;
            2'd2: begin
                r = (x >>> 2) + ONE / 2;
                if (r < 0)   r = 0;
                if (r > ONE) r = ONE;
            end
            default: r = (x > 0) ? ONE : 0;
        endcase
        y = DW'(r);
    endfunction

    task automatic set_all(input logic [DW-1:0] c, input logic [DW-1:0] d);
        for (int k = 0; k < N_IN; k++) begin
            t_coef[k] = c;
            t_data[k] = d;
        end
    endtask

    // One full evaluation; starts and ends at a falling edge with the DUT idle
    task automatic run_eval(input logic [1:0] m, input logic [DW-1:0] b, input bit gaps,
                            input int hold, input string tag, output logic [DW-1:0] res);
        logic [DW-1:0] ey;
        logic          es;
        int            i;
        model(m, b, ey, es);
        start    = 1'b1;
        act_mode = m;
        bias     = b;
        @(negedge clk);
        start = 1'b0;
        check_value({tag, "_busy"}, 16'(busy), 16'd1);
        check_value({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        i = 0;
        while (i < N_IN) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                bus.coef     = 16'($urandom);
                bus.data_in  = 16'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.coef     = t_coef[i];
                bus.data_in  = t_data[i];
                i++;
            end
            if (gaps) begin
                start    = 1'($urandom_range(0, 1));
                bias     = 16'($urandom);
                act_mode = 2'($urandom);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        check_value({tag, "_lat1_valid"}, 16'(bus.out_valid), 16'd0);
        check_value({tag, "_lat1_ready"}, 16'(bus.in_ready), 16'd0);
        @(negedge clk);
        check_value({tag, "_lat2_valid"}, 16'(bus.out_valid), 16'd1);
        check_value({tag, "_node_out"}, bus.node_out, ey);
        check_value({tag, "_sat"}, 16'(bus.sat), 16'(es));
        res = bus.node_out;
        for (int h = 0; h < hold; h++) begin
            start    = 1'b1;
            bias     = 16'($urandom);
            act_mode = 2'($urandom);
            @(negedge clk);
        end
        if (hold > 0) begin
            check_value({tag, "_hold_valid"}, 16'(bus.out_valid), 16'd1);
            check_value({tag, "_hold_out"}, bus.node_out, ey);
            check_value({tag, "_hold_sat"}, 16'(bus.sat), 16'(es));
        end
        start         = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_value({tag, "_idle_busy"}, 16'(busy), 16'd0);
        check_value({tag, "_idle_valid"}, 16'(bus.out_valid), 16'd0);
        check_value({tag, "_idle_keep"}, bus.node_out, ey);
    endtask

    // Guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Stimulus and checks
    initial begin
        bus.in_valid  = 1'b0;
        bus.coef      = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        #12;
        check_value("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check_value("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check_value("rst_node_out", bus.node_out, 16'h0000);
        check_value("rst_sat", 16'(bus.sat), 16'd0);
        check_value("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: 1+2+3+4 with unity weights
        for (int k = 0; k < N_IN; k++) begin
            t_coef[k] = 16'h0100;
            t_data[k] = 16'((k + 1) * 256);
        end
        run_eval(2'd0, 16'h0000, 1'b0, 0, "t1", got);
        check_value("t1_const", got, 16'h0A00);

        // 2: 1.0 + 4*(-1.0*2.0) = -7.0 under identity, ReLU, step
        set_all(16'hFF00, 16'h0200);
        run_eval(2'd0, 16'h0100, 1'b0, 0, "t2_m0", got);
        check_value("t2_m0_const", got, 16'hF900);
        run_eval(2'd1, 16'h0100, 1'b0, 0, "t2_m1", got);
        check_value("t2_m1_const", got, 16'h0000);
        run_eval(2'd3, 16'h0100, 1'b0, 0, "t2_m3", got);
        check_value("t2_m3_const", got, 16'h0000);

        // 3: hard-sigmoid at 0, +4.0, -4.0
        set_all(16'h0000, 16'h0000);
        run_eval(2'd2, 16'h0000, 1'b0, 0, "t3_zero", got);
        check_value("t3_zero_const", got, 16'h0080);
        set_all(16'h0100, 16'h0100);
        run_eval(2'd2, 16'h0000, 1'b0, 0, "t3_pos", got);
        check_value("t3_pos_const", got, 16'h0100);
        set_all(16'hFF00, 16'h0100);
        run_eval(2'd2, 16'h0000, 1'b0, 0, "t3_neg", got);
        check_value("t3_neg_const", got, 16'h0000);

        // 4: positive saturation from extreme operands
        set_all(16'h7FFF, 16'h7FFF);
        run_eval(2'd0, 16'h0000, 1'b0, 0, "t4_max", got);
        check_value("t4_max_const", got, 16'h7FFF);
        check_value("t4_max_satflag", 16'(bus.sat), 16'd1);
        set_all(16'h8000, 16'h8000);
        run_eval(2'd0, 16'h0000, 1'b0, 0, "t4_min", got);
        check_value("t4_min_const", got, 16'h7FFF);

        // 5: test-1 stimulus with valid gaps, stray starts and back-pressure
        for (int k = 0; k < N_IN; k++) begin
            t_coef[k] = 16'h0100;
            t_data[k] = 16'((k + 1) * 256);
        end
        run_eval(2'd0, 16'h0000, 1'b1, 5, "t5", got);
        check_value("t5_const", got, 16'h0A00);

        // 6: reset in the middle of accumulation
        start    = 1'b1;
        act_mode = 2'd0;
        bias     = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.coef     = t_coef[k];
            bus.data_in  = t_data[k];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check_value("t6_in_ready", 16'(bus.in_ready), 16'd0);
        check_value("t6_out_valid", 16'(bus.out_valid), 16'd0);
        check_value("t6_node_out", bus.node_out, 16'h0000);
        check_value("t6_sat", 16'(bus.sat), 16'd0);
        check_value("t6_busy", 16'(busy), 16'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_eval(2'd0, 16'h0000, 1'b0, 0, "t6_after", got);
        check_value("t6_after_const", got, 16'h0A00);

        // Randomised evaluations against the model
        for (int r = 0; r < 16; r++) begin
            bit full;
            full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N_IN; k++) begin
                if (full) begin
                    t_coef[k] = 16'($urandom);
                    t_data[k] = 16'($urandom);
                end else begin
                    t_coef[k] = 16'($urandom_range(0, 1023) - 512);
                    t_data[k] = 16'($urandom_range(0, 2047) - 1024);
                end
            end
            run_eval(2'($urandom), 16'($urandom_range(0, 4095) - 2048),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rnd", got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
